mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory line port (mem_req_type / mem_data_type) between the instruction-cache and data-cache FSMs.
- Grants one requester at a time and captures its request into a holding register. It replays that request to memory until memory signals ready, then routes the response back to the owner only.
- Sits between both cache controllers and the memory model / memory controller.

Parameters:
- ADDR_W, 32, request address width (must match mem_req_type.addr).
- LINE_W, 128, cache line width (must match mem_req_type.data and mem_data_type.data).
- D_PRIORITY, 1: 1 = data cache wins simultaneous requests, subject to STARVE_LIMIT; 0 = pure round-robin.
- STARVE_LIMIT, 3: consecutive D grants allowed while I is waiting, before I is forced. Range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_mem_req  in  mem_req_type  I-cache request: valid, rw, addr[ADDR_W], data[LINE_W].
- i_mem_data  out  mem_data_type  I-cache response: ready, data[LINE_W].
- d_mem_req  in  mem_req_type  D-cache request.
- d_mem_data  out  mem_data_type  D-cache response.
- mem_req  out  mem_req_type  request to memory.
- mem_data  in  mem_data_type  memory response.
- busy  out  1  high while a transaction is owned.
- owner  out  1  0 = I, 1 = D; meaningful only when busy is high.

Behaviour:
- Reset (reset low, asynchronous):
  - state = ARB_IDLE.
  - holding register cleared to zeros.
  - owner = 0, last_grant = D, starve_cnt = 0.
  - mem_req.valid = 0; i/d_mem_data.ready = 0; all data outputs = 0; busy = 0.
- States: ARB_IDLE, ARB_ISSUE.
- ARB_IDLE:
  - mem_req.valid = 0.
  - If any request valid is high, pick a winner and latch the winner's {rw, addr, data} into the holding register.
  - Set owner, then go to ARB_ISSUE next cycle.
  - mem_data.ready arriving while in ARB_IDLE is ignored and not forwarded. This covers stale responses after a reset.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid, D_PRIORITY = 0: the requester that is not last_grant wins.
  - Both valid, D_PRIORITY = 1: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - starve_cnt: increments on each D grant made while I is valid; clears on any I grant; saturates at STARVE_LIMIT.
- ARB_ISSUE:
  - mem_req = holding register with valid = 1, held stable every cycle.
  - Requester inputs are not sampled. Requesters may drop valid during a write-back; the holding register covers this.
  - busy = 1.
  - When mem_data.ready = 1:
    - same cycle, combinationally: owner's response = {ready 1, mem_data.data}. The non-owner sees ready = 0 and data = 0.
    - next cycle: state goes to ARB_IDLE and last_grant <= owner.
- Latency:
  - Request visible at cycle N produces mem_req.valid at N+1.
  - Memory ready at cycle M produces owner ready at M (zero added latency on return).
  - Earliest re-arbitration is M+1. A requester therefore sees a minimum of 1 added cycle per transaction.
- Back-to-back:
  - A D write-back followed by its allocate read is two separate grants. I may be granted in between; this is permitted.
- Response width: the owner's response is exactly 1 cycle per transaction.
- Non-owner during ISSUE: its valid is held off, unanswered, until it is granted.
- Reset during ARB_ISSUE: the transaction is abandoned immediately and mem_req.valid drops asynchronously. Memory must tolerate an abandoned request.
- mem_req.data is passed through only; no modification.

Decomposition:
- mem_req_type, mem_data_type and the new arb_owner_e (ARB_I = 0, ARB_D = 1) live in the shared cache package/header.
- The state enum stays local to the block.
- One sub-module is natural: arb_pick, a combinational winner selector with inputs i_valid, d_valid, last_grant, starve_cnt and parameters. It is unit-testable alone.

Test Plan:
- Single I read, addr 0x0000_0040, memory ready after 3 cycles with data 0xDEAD..BEEF:
  - mem_req.valid rises 1 cycle after i valid, addr = 0x40, rw = 0.
  - i_mem_data.ready pulses 1 cycle with that data; d_mem_data.ready stays 0.
- D write-back, rw = 1, addr 0x0000_0130, data 0x1111_2222_3333_4444..., with d valid dropped after 1 cycle:
  - mem_req holds rw = 1, addr = 0x130 and the full data until ready.
  - d ready pulses once.
- Simultaneous I and D valid, D_PRIORITY = 0, after reset:
  - grant order is I, D, I, D (last_grant reset = D).
  - owner output matches each transaction.
- D_PRIORITY = 1, STARVE_LIMIT = 3, D valid continuously, I valid continuously:
  - grants are D, D, D, I, D, D, D, I.
- Reset asserted mid-ARB_ISSUE:
  - mem_req.valid = 0 immediately.
  - a memory ready 2 cycles after reset release produces no i/d ready pulse.
- Memory ready in the same cycle as first issue (0-wait memory):
  - owner ready occurs at N+1; the next request is granted at N+2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared cache/memory line-port types and the arbiter owner encoding.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W   = 32;
  localparam int MEM_LINE_W   = 128;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LINE_W-1:0] data;
  } mem_req_type;

  typedef struct packed {
    logic                  ready;
    logic [MEM_LINE_W-1:0] data;
  } mem_data_type;

  // Saturating increment used by the starvation counter.
  function automatic logic [STARVE_CNT_W-1:0] sat_inc(
    input logic [STARVE_CNT_W-1:0] value,
    input logic [STARVE_CNT_W-1:0] limit
  );
    if (value >= limit) begin
      return limit;
    end
    return value + STARVE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int D_PRIORITY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    i_valid,
  input  logic                    d_valid,
  input  arb_owner_e              last_grant,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    grant_valid,
  output arb_owner_e              winner
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  // A lone requester always wins; a tie is broken by priority mode.
  always_comb begin
    grant_valid = i_valid | d_valid;
    winner      = ARB_I;
    if (d_valid && !i_valid) begin
      winner = ARB_D;
    end else if (i_valid && d_valid) begin
      if (D_PRIORITY != 0) begin
        // D normally wins, but I is forced once it has waited STARVE_LIMIT grants.
        winner = (starve_cnt == STARVE_MAX) ? ARB_I : ARB_D;
      end else begin
        winner = (last_grant == ARB_D) ? ARB_I : ARB_D;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory line port between the I-cache and D-cache controllers.
// The granted request is captured into a holding register and replayed until
// memory signals ready; the response is routed to the owner only.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int LINE_W       = MEM_LINE_W,
  parameter int D_PRIORITY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  mem_req_type  i_mem_req,
  output mem_data_type i_mem_data,
  input  mem_req_type  d_mem_req,
  output mem_data_type d_mem_data,
  output mem_req_type  mem_req,
  input  mem_data_type mem_data,
  output logic         busy,
  output logic         owner
);

  // state     | meaning
  // ARB_IDLE  | no transaction owned; arbitrate and latch the winner
  // ARB_ISSUE | holding register driven to memory until mem_data.ready
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state;
  arb_state_e              state_nxt;
  logic                    grant_take;
  logic                    pick_valid;
  arb_owner_e              pick_winner;
  arb_owner_e              owner_q;
  arb_owner_e              last_grant;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  mem_req_type             win_req;
  logic                    hold_rw;
  logic [ADDR_W-1:0]       hold_addr;
  logic [LINE_W-1:0]       hold_data;

  arb_pick #(
    .D_PRIORITY   (D_PRIORITY),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_valid     (i_mem_req.valid),
    .d_valid     (d_mem_req.valid),
    .last_grant  (last_grant),
    .starve_cnt  (starve_cnt),
    .grant_valid (pick_valid),
    .winner      (pick_winner)
  );

  // Request of whichever side the selector chose this cycle.
  always_comb begin
    win_req = (pick_winner == ARB_D) ? d_mem_req : i_mem_req;
  end

  // State register; reset drops mem_req.valid asynchronously via ARB_IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; responses are combinational from mem_data.
  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    busy       = 1'b0;
    mem_req    = '0;
    i_mem_data = '0;
    d_mem_data = '0;
    case (state)
      ARB_IDLE: begin
        // A ready arriving here is stale (e.g. after reset) and is dropped.
        if (pick_valid) begin
          grant_take = 1'b1;
          state_nxt  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        busy          = 1'b1;
        mem_req.valid = 1'b1;
        mem_req.rw    = hold_rw;
        mem_req.addr  = hold_addr;
        mem_req.data  = hold_data;
        if (mem_data.ready) begin
          state_nxt = ARB_IDLE;
          if (owner_q == ARB_D) begin
            d_mem_data.ready = 1'b1;
            d_mem_data.data  = mem_data.data;
          end else begin
            i_mem_data.ready = 1'b1;
            i_mem_data.data  = mem_data.data;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Holding register, ownership and fairness bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_rw    <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      owner_q    <= ARB_I;
      last_grant <= ARB_D;
      starve_cnt <= '0;
    end else begin
      if (grant_take) begin
        owner_q   <= pick_winner;
        hold_rw   <= win_req.rw;
        hold_addr <= win_req.addr;
        hold_data <= win_req.data;
        if (pick_winner == ARB_I) begin
          starve_cnt <= '0;
        end else if (i_mem_req.valid) begin
          // D took the port while I was waiting.
          starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
        end
      end
      if (state == ARB_ISSUE && mem_data.ready) begin
        last_grant <= owner_q;
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one priority instance, one round-robin.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic         owner;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  logic         clock;
  logic         reset;
  bit           sel;
  mem_req_type  i_req, d_req, rr_i_req, rr_d_req;
  mem_req_type  p_mem_req, rr_mem_req, c_mem_req;
  mem_data_type i_rsp, d_rsp, rr_i_rsp, rr_d_rsp, c_i_rsp, c_d_rsp;
  mem_data_type mem_rsp;
  logic         p_busy, rr_busy, c_busy;
  logic         p_owner, rr_owner, c_owner;
  int           checks;
  int           errors;
  exp_t         exp_q[$];

  mem_port_arbiter #(.D_PRIORITY(1), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .i_mem_req(i_req), .i_mem_data(i_rsp),
    .d_mem_req(d_req), .d_mem_data(d_rsp),
    .mem_req(p_mem_req), .mem_data(mem_rsp),
    .busy(p_busy), .owner(p_owner)
  );

  mem_port_arbiter #(.D_PRIORITY(0), .STARVE_LIMIT(3)) dut_rr (
    .clock(clock), .reset(reset),
    .i_mem_req(rr_i_req), .i_mem_data(rr_i_rsp),
    .d_mem_req(rr_d_req), .d_mem_data(rr_d_rsp),
    .mem_req(rr_mem_req), .mem_data(mem_rsp),
    .busy(rr_busy), .owner(rr_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    c_mem_req = sel ? rr_mem_req : p_mem_req;
    c_i_rsp   = sel ? rr_i_rsp : i_rsp;
    c_d_rsp   = sel ? rr_d_rsp : d_rsp;
    c_busy    = sel ? rr_busy : p_busy;
    c_owner   = sel ? rr_owner : p_owner;
  end

  // Waits (bounded) for the selected instance to present mem_req.valid.
  task automatic wait_issue(output int cyc);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      cyc++;
      if (c_mem_req.valid) break;
    end
  endtask

  // Memory model: called on the first issue cycle, answers after wait_cyc cycles.
  task automatic mem_respond(input int wait_cyc, input logic [127:0] rdata,
                             input bit release_owner, output mem_req_type first,
                             output bit stable, output mem_data_type ir,
                             output mem_data_type dr, output logic own,
                             output int pulses, output logic busy_after);
    first  = c_mem_req;
    own    = c_owner;
    stable = 1'b1;
    for (int k = 0; k < wait_cyc; k++) begin
      @(negedge clock);
      if (c_mem_req !== first || c_busy !== 1'b1) stable = 1'b0;
    end
    mem_rsp = '{ready: 1'b1, data: rdata};
    #1;
    ir = c_i_rsp;
    dr = c_d_rsp;
    if (c_mem_req !== first) stable = 1'b0;
    pulses = 0;
    if (ir.ready) pulses++;
    if (dr.ready) pulses++;
    if (release_owner) begin
      if (sel) begin
        if (own) rr_d_req.valid = 1'b0; else rr_i_req.valid = 1'b0;
      end else begin
        if (own) d_req.valid = 1'b0; else i_req.valid = 1'b0;
      end
    end
    @(negedge clock);
    busy_after = c_busy;
    #1;
    if (c_i_rsp.ready || c_d_rsp.ready) pulses++;
    mem_rsp = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (p_mem_req !== '0 || rr_mem_req !== '0) begin
      errors++;
      $display("FAIL reset_mem_req: got valid=%b/%b, expected all-zero", p_mem_req.valid, rr_mem_req.valid);
    end
    checks++;
    if (i_rsp !== '0 || d_rsp !== '0) begin
      errors++;
      $display("FAIL reset_responses: got i=%b d=%b, expected ready 0 data 0", i_rsp.ready, d_rsp.ready);
    end
    checks++;
    if (p_busy !== 1'b0 || p_owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_owner: got busy=%b owner=%b, expected 0 0", p_busy, p_owner);
    end
    reset = 1'b1;
    @(negedge clock);
    mem_rsp = '{ready: 1'b1, data: {4{32'h5A5A_A5A5}}};
    #1;
    checks++;
    if (i_rsp !== '0 || d_rsp !== '0 || p_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready_ignored: got i=%b d=%b busy=%b, expected 0 0 0", i_rsp.ready, d_rsp.ready, p_busy);
    end
    @(negedge clock);
    mem_rsp = '0;
  endtask

  task automatic test_single_i_read();
    exp_t e; mem_req_type first; mem_data_type ir, dr;
    logic own, busy_after; bit stable; int cyc, pulses;
    sel = 1'b0;
    exp_q.push_back('{owner: 1'b0, rw: 1'b0, addr: 32'h0000_0040, wdata: '0,
                      rdata: {4{32'hDEAD_BEEF}}});
    i_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0040, data: '0};
    wait_issue(cyc);
    checks++;
    if (cyc !== 1 || c_mem_req.valid !== 1'b1) begin
      errors++;
      $display("FAIL i_read_latency: got %0d cycles valid=%b, expected 1 cycle valid=1", cyc, c_mem_req.valid);
    end
    mem_respond(3, {4{32'hDEAD_BEEF}}, 1'b1, first, stable, ir, dr, own, pulses, busy_after);
    e = exp_q.pop_front();
    checks++;
    if (first.rw !== e.rw || first.addr !== e.addr || own !== e.owner || !stable) begin
      errors++;
      $display("FAIL i_read_request: got rw=%b addr=%h owner=%b stable=%b, expected rw=%b addr=%h owner=%b stable=1",
               first.rw, first.addr, own, stable, e.rw, e.addr, e.owner);
    end
    checks++;
    if (ir.ready !== 1'b1 || ir.data !== e.rdata) begin
      errors++;
      $display("FAIL i_read_response: got ready=%b data=%h, expected 1 %h", ir.ready, ir.data, e.rdata);
    end
    checks++;
    if (dr !== '0 || pulses !== 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL i_read_single_pulse: got d_ready=%b pulses=%0d busy=%b, expected 0 1 0", dr.ready, pulses, busy_after);
    end
  endtask

  task automatic test_d_writeback();
    exp_t e; mem_req_type first; mem_data_type ir, dr;
    logic own, busy_after; bit stable; int cyc, pulses;
    logic [127:0] wline;
    sel = 1'b0;
    wline = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    exp_q.push_back('{owner: 1'b1, rw: 1'b1, addr: 32'h0000_0130, wdata: wline,
                      rdata: {4{32'h0BAD_F00D}}});
    d_req = '{valid: 1'b1, rw: 1'b1, addr: 32'h0000_0130, data: wline};
    wait_issue(cyc);
    // The cache abandons its inputs; the holding register must cover this.
    d_req = '{valid: 1'b0, rw: 1'b0, addr: 32'hFFFF_FFFF, data: '1};
    checks++;
    if (cyc !== 1 || c_mem_req.valid !== 1'b1) begin
      errors++;
      $display("FAIL wb_latency: got %0d cycles valid=%b, expected 1 cycle valid=1", cyc, c_mem_req.valid);
    end
    mem_respond(3, {4{32'h0BAD_F00D}}, 1'b0, first, stable, ir, dr, own, pulses, busy_after);
    e = exp_q.pop_front();
    checks++;
    if (first.rw !== e.rw || first.addr !== e.addr || first.data !== e.wdata || !stable) begin
      errors++;
      $display("FAIL wb_request_held: got rw=%b addr=%h data=%h stable=%b, expected rw=%b addr=%h data=%h stable=1",
               first.rw, first.addr, first.data, stable, e.rw, e.addr, e.wdata);
    end
    checks++;
    if (own !== e.owner || dr.ready !== 1'b1 || dr.data !== e.rdata) begin
      errors++;
      $display("FAIL wb_response: got owner=%b ready=%b data=%h, expected %b 1 %h", own, dr.ready, dr.data, e.owner, e.rdata);
    end
    checks++;
    if (ir !== '0 || pulses !== 1) begin
      errors++;
      $display("FAIL wb_single_pulse: got i_ready=%b pulses=%0d, expected 0 1", ir.ready, pulses);
    end
  endtask

  task automatic test_round_robin();
    exp_t e; mem_req_type first; mem_data_type ir, dr;
    logic own, busy_after; bit stable; int cyc, pulses;
    logic [127:0] rd;
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{owner: (k % 2 == 1), rw: 1'b0,
                        addr: (k % 2 == 1) ? 32'h0000_0600 : 32'h0000_0500,
                        wdata: '0, rdata: {4{32'hC000_0000 + 32'(k)}}});
    end
    rr_i_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0500, data: '0};
    rr_d_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0600, data: '0};
    for (int k = 0; k < 4; k++) begin
      wait_issue(cyc);
      rd = {4{32'hC000_0000 + 32'(k)}};
      mem_respond(1, rd, 1'b0, first, stable, ir, dr, own, pulses, busy_after);
      e = exp_q.pop_front();
      checks++;
      if (own !== e.owner || first.addr !== e.addr || first.valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant_%0d: got owner=%b addr=%h valid=%b, expected owner=%b addr=%h valid=1",
                 k, own, first.addr, first.valid, e.owner, e.addr);
      end
      checks++;
      if ((e.owner ? dr.data : ir.data) !== e.rdata || pulses !== 1 || (e.owner ? ir.ready : dr.ready) !== 1'b0) begin
        errors++;
        $display("FAIL rr_response_%0d: got i_ready=%b d_ready=%b pulses=%0d, expected only owner %b with %h",
                 k, ir.ready, dr.ready, pulses, e.owner, e.rdata);
      end
    end
    rr_i_req = '0;
    rr_d_req = '0;
    sel = 1'b0;
  endtask

  task automatic test_starve();
    exp_t e; mem_req_type first; mem_data_type ir, dr;
    logic own, busy_after; bit stable; int cyc, pulses;
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{owner: (k % 4 != 3), rw: 1'b0,
                        addr: (k % 4 != 3) ? 32'h0000_2000 : 32'h0000_1000,
                        wdata: '0, rdata: {4{32'hA000_0000 + 32'(k)}}});
    end
    i_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_1000, data: '0};
    d_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_2000, data: '0};
    for (int k = 0; k < 8; k++) begin
      wait_issue(cyc);
      mem_respond(1, {4{32'hA000_0000 + 32'(k)}}, 1'b0, first, stable, ir, dr, own, pulses, busy_after);
      e = exp_q.pop_front();
      checks++;
      if (own !== e.owner || first.addr !== e.addr || (e.owner ? dr.data : ir.data) !== e.rdata || pulses !== 1) begin
        errors++;
        $display("FAIL starve_grant_%0d: got owner=%b addr=%h pulses=%0d, expected owner=%b addr=%h pulses=1",
                 k, own, first.addr, pulses, e.owner, e.addr);
      end
    end
    i_req = '0;
    d_req = '0;
  endtask

  task automatic test_reset_mid_issue();
    int cyc;
    sel = 1'b0;
    i_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0880, data: '0};
    wait_issue(cyc);
    checks++;
    if (c_mem_req.valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: got valid=%b after %0d cycles, expected 1", c_mem_req.valid, cyc);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (p_mem_req.valid !== 1'b0 || p_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_drop: got valid=%b busy=%b, expected 0 0", p_mem_req.valid, p_busy);
    end
    i_req = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    mem_rsp = '{ready: 1'b1, data: {4{32'hFEED_FACE}}};
    #1;
    checks++;
    if (i_rsp !== '0 || d_rsp !== '0 || p_mem_req.valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_stale_ready: got i=%b d=%b valid=%b, expected 0 0 0", i_rsp.ready, d_rsp.ready, p_mem_req.valid);
    end
    @(negedge clock);
    mem_rsp = '0;
  endtask

  task automatic test_zero_wait();
    exp_t e; mem_req_type first; mem_data_type ir, dr;
    logic own, busy_after; bit stable; int cyc, pulses;
    sel = 1'b0;
    exp_q.push_back('{owner: 1'b1, rw: 1'b0, addr: 32'h0000_0300, wdata: '0, rdata: {4{32'h1234_5678}}});
    d_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0300, data: '0};
    wait_issue(cyc);
    e = exp_q.pop_front();
    // Memory answers on the very first issue cycle; I raises its request now.
    mem_rsp = '{ready: 1'b1, data: e.rdata};
    d_req = '0;
    i_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0400, data: '0};
    exp_q.push_back('{owner: 1'b0, rw: 1'b0, addr: 32'h0000_0400, wdata: '0, rdata: {4{32'h8765_4321}}});
    #1;
    checks++;
    if (cyc !== 1 || d_rsp.ready !== 1'b1 || d_rsp.data !== e.rdata || i_rsp.ready !== 1'b0) begin
      errors++;
      $display("FAIL zw_response: got cyc=%0d d_ready=%b d_data=%h i_ready=%b, expected 1 1 %h 0",
               cyc, d_rsp.ready, d_rsp.data, i_rsp.ready, e.rdata);
    end
    @(negedge clock);
    mem_rsp = '0;
    checks++;
    if (p_busy !== 1'b0) begin
      errors++;
      $display("FAIL zw_idle_gap: got busy=%b, expected 0", p_busy);
    end
    wait_issue(cyc);
    mem_respond(1, {4{32'h8765_4321}}, 1'b1, first, stable, ir, dr, own, pulses, busy_after);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 1 || own !== e.owner || first.addr !== e.addr || ir.data !== e.rdata || pulses !== 1) begin
      errors++;
      $display("FAIL zw_next_grant: got cyc=%0d owner=%b addr=%h pulses=%0d, expected 1 %b %h 1",
               cyc, own, first.addr, pulses, e.owner, e.addr);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sel      = 1'b0;
    reset    = 1'b0;
    i_req    = '0;
    d_req    = '0;
    rr_i_req = '0;
    rr_d_req = '0;
    mem_rsp  = '0;
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_round_robin();
    test_starve();
    test_reset_mid_issue();
    test_zero_wait();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
